// File: rtl/aes_round_key_stage.sv
// Registered AddRoundKey stage behind MixColumns; tracks round count per block.
// Optional `AES_RK_STAGE_BLKCNT_EN adds a completed-block counter output.
module aes_round_key_stage #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_start,
    input  logic [127:0]  plain_data,
    input  logic [127:0]  shift_data,
    input  logic [127:0]  mix_data,
    output logic [RW-1:0] rk_index,
    input  logic [127:0]  rk_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [RW-1:0] out_round,
    output logic          out_last,
`ifdef AES_RK_STAGE_BLKCNT_EN
    output logic [15:0]   blk_count,
`endif
    output logic          seq_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [RW-1:0] NR_IDX = RW'(NR);

    state_e        state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;

    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_data_q, out_data_d;
    logic [RW-1:0] out_round_q, out_round_d;
    logic          out_last_q, out_last_d;
    logic          err_q, err_d;

    logic          accept;
    logic          emit;
    logic [RW-1:0] idx;
    logic [127:0]  sel;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A non-start beat in IDLE is consumed but produces nothing.
    assign emit     = accept && (in_start || state_q == RUN);
    assign idx      = in_start ? '0 : rnd_q;
    assign rk_index = idx;

    always_comb begin
        sel = mix_data;
        if (in_start) begin
            sel = plain_data;
        end else if (rnd_q == NR_IDX) begin
            sel = shift_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        if (accept) begin
            if (in_start) begin
                state_d = RUN;
                rnd_d   = RW'(1);
            end else if (state_q == RUN) begin
                if (rnd_q == NR_IDX) begin
                    state_d = IDLE;
                    rnd_d   = '0;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = sel ^ rk_data;
            out_round_d = idx;
            out_last_d  = (idx == NR_IDX);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && (in_start ? (state_q == RUN) : (state_q == IDLE))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign seq_err   = err_q;

`ifdef AES_RK_STAGE_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_last_q) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_count = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_key_stage.sv
// Directed bench for aes_round_key_stage: FIPS-197 vectors, handshake,
// protocol errors and async reset.
module tb_aes_round_key_stage;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_start;
    logic [127:0]  plain_data;
    logic [127:0]  shift_data;
    logic [127:0]  mix_data;
    logic [RW-1:0] rk_index;
    logic [127:0]  rk_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic [RW-1:0] out_round;
    logic          out_last;
    logic          seq_err;
`ifdef AES_RK_STAGE_BLKCNT_EN
    logic [15:0]   blk_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    aes_round_key_stage #(.NR(NR), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_start   (in_start),
        .plain_data (plain_data),
        .shift_data (shift_data),
        .mix_data   (mix_data),
        .rk_index   (rk_index),
        .rk_data    (rk_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_round  (out_round),
        .out_last   (out_last),
`ifdef AES_RK_STAGE_BLKCNT_EN
        .blk_count  (blk_count),
`endif
        .seq_err    (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Distinct per (round, kind): kind 0 plain, 1 mix, 2 shift, 3 key.
    function automatic logic [127:0] pat(input int r, input int k);
        logic [31:0] a;
        a = 32'h9e3779b9 * 32'(r * 4 + k + 1);
        return {a, a ^ 32'h5a5a1234, ~a, {a[15:0], a[31:16]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    // Present round r (r==0 means start) and check the registered result.
    task automatic send(input int r, input bit fips);
        logic [127:0] p, m, s, k, e;
        p = pat(r, 0);
        m = pat(r, 1);
        s = pat(r, 2);
        k = pat(r, 3);
        if (r == 0) e = p ^ k;
        else if (r == NR) e = s ^ k;
        else e = m ^ k;
        if (fips && r == 0) begin
            p = 128'h3243f6a8885a308d313198a2e0370734;
            k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            e = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        end
        if (fips && r == NR) begin
            s = 128'he9317db5cb322c723d2e895faf090794;
            k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            e = 128'h3925841d02dc09fbdc118597196a0b32;
        end
        in_valid   = 1'b1;
        in_start   = (r == 0);
        plain_data = p;
        mix_data   = m;
        shift_data = s;
        rk_data    = k;
        #1;
        chk("rk_index", 128'(rk_index), 128'(r));
        tick();
        chk("out_valid", 128'(out_valid), 128'(1));
        chk("out_round", 128'(out_round), 128'(r));
        chk("out_data", out_data, e);
        chk("out_last", 128'(out_last), 128'(r == NR));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_start   = 1'b0;
        plain_data = '0;
        shift_data = '0;
        mix_data   = '0;
        rk_data    = '0;
        out_ready  = 1'b1;

        tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_round", 128'(out_round), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_seq_err", 128'(seq_err), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_rk_index", 128'(rk_index), 128'(0));

        // FIPS-197 block with idle gaps between beats
        for (int r = 0; r <= NR; r++) begin
            send(r, 1'b1);
            in_valid = 1'b0;
            tick();
            chk("drain_valid", 128'(out_valid), 128'(0));
        end
        chk("fips_seq_err", 128'(seq_err), 128'(0));

        // back-to-back beats
        for (int r = 0; r <= NR; r++) send(r, 1'b0);
        in_valid = 1'b0;
        tick();

        // back-pressure after round 3
        for (int r = 0; r <= 3; r++) send(r, 1'b0);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_start   = 1'b0;
        mix_data   = pat(4, 1);
        shift_data = pat(4, 2);
        rk_data    = pat(4, 3);
        #1;
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_round", 128'(out_round), 128'(3));
            chk("bp_data", out_data, pat(3, 1) ^ pat(3, 3));
            chk("bp_rk_index", 128'(rk_index), 128'(4));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        tick();
        chk("bp_r4_valid", 128'(out_valid), 128'(1));
        chk("bp_r4_round", 128'(out_round), 128'(4));
        chk("bp_r4_data", out_data, pat(4, 1) ^ pat(4, 3));
        for (int r = 5; r <= NR; r++) send(r, 1'b0);
        in_valid = 1'b0;
        tick();

        // restart in the middle of a block
        rst_pulse();
        for (int r = 0; r <= 4; r++) send(r, 1'b0);
        chk("abort_pre_err", 128'(seq_err), 128'(0));
        send(0, 1'b0);
        chk("abort_seq_err", 128'(seq_err), 128'(1));
        for (int r = 1; r <= NR; r++) send(r, 1'b0);
        in_valid = 1'b0;
        tick();

        // non-start beat while idle
        rst_pulse();
        in_valid = 1'b1;
        in_start = 1'b0;
        tick();
        chk("idle_drop_valid", 128'(out_valid), 128'(0));
        chk("idle_seq_err", 128'(seq_err), 128'(1));
        in_valid = 1'b0;
        tick();
        chk("idle_after_valid", 128'(out_valid), 128'(0));

        // async reset at round 6 while a result is pending
        rst_pulse();
        for (int r = 0; r <= 6; r++) send(r, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_data", out_data, 128'(0));
        chk("arst_round", 128'(out_round), 128'(0));
        #1;
        rst_n = 1'b1;
        #1;
        for (int r = 0; r <= NR; r++) send(r, 1'b0);
        chk("arst_seq_err", 128'(seq_err), 128'(0));
        in_valid = 1'b0;
        tick();

`ifdef AES_RK_STAGE_BLKCNT_EN
        rst_pulse();
        chk("blk_rst", 128'(blk_count), 128'(0));
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r <= NR; r++) send(r, 1'b0);
            in_valid = 1'b0;
            tick();
        end
        chk("blk_three", 128'(blk_count), 128'(3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_key_stage.md
Name: aes_round_key_stage

Overview:
- Registered AddRoundKey stage directly downstream of the combinational MixColumns block in the AES encryption datapath.
- Accepts one 128-bit state per beat and selects between the post-MixColumns state and the pre-MixColumns (ShiftRows) state, or raw plaintext on round 0.
- XORs the selected state with the round key fetched by round index and registers the result behind a valid/ready handshake.
- Tracks the round number per block and flags the final round so the output can leave the round loop.

Parameters:
- NR, 10, number of AES rounds; legal values 10, 12, 14.
- RW, 4, width of round index; must satisfy 2^RW > NR.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_start  input  1  beat is round 0 of a new block (plaintext)
- plain_data  input  128  plaintext; used only when in_start=1
- shift_data  input  128  ShiftRows output (pre-MixColumns state)
- mix_data  input  128  MixColumns output
- rk_index  output  RW  round index being requested; combinational
- rk_data  input  128  round key for rk_index, valid in the same cycle
- out_valid  output  1  out_data holds a result
- out_ready  input  1  downstream accepts result
- out_data  output  128  state after AddRoundKey
- out_round  output  RW  round index applied to out_data
- out_last  output  1  out_data is the final ciphertext (round NR)
- seq_err  output  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_round=0, out_last=0, seq_err=0, round counter rnd=0, FSM=IDLE. in_ready=1 after reset is released.
- Handshake:
  - in_ready = !out_valid || out_ready; this is a single-register stage with no skid buffer.
  - A beat is accepted when in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
- FSM states: IDLE (no block in flight), RUN (rounds 1..NR expected).
  - IDLE: accepted beat with in_start=1 → round 0, goes to RUN with rnd=1.
  - IDLE: accepted beat with in_start=0 → dropped (no output), seq_err=1, stays IDLE.
  - RUN: accepted beat with in_start=0 → round rnd; rnd increments. If rnd==NR, out_last=1 and the FSM returns to IDLE with rnd=0.
  - RUN: accepted beat with in_start=1 → aborts the current block, seq_err=1, and is treated as round 0 of a new block (rnd=1, stays RUN).
- Data select for the accepted beat:
  - round 0: plain_data
  - rounds 1..NR-1: mix_data
  - round NR: shift_data (the final round has no MixColumns)
- rk_index (combinational) = 0 if in_start, else the current rnd.
- Latency is 1 cycle. On acceptance: out_data <= sel ^ rk_data, out_round <= index, out_last <= (index==NR), out_valid <= 1.
- If there is no acceptance and out_ready=1, out_valid <= 0; out_data keeps its last value.
- A simultaneous output drain and new acceptance in the same cycle gives full throughput (one beat per cycle).
- seq_err clears only on reset.
- Reset asserted mid-block: all state is lost immediately. The first beat after reset must carry in_start.

Optional Feature:
- Macro: AES_RK_STAGE_BLKCNT_EN.
- Defined: adds output blk_count [15:0], reset 0, incremented when a beat with out_last=1 is accepted downstream (out_valid && out_ready && out_last). Wraps 0xFFFF→0x0000.
- Undefined: port absent; no counter logic.

Test Plan:
- FIPS-197 Appendix B (NR=10): plaintext 3243f6a8885a308d313198a2e0370734 with the expanded key for 2b7e151628aed2a6abf7158809cf4f3c, round states fed per round → round-0 out_data=193de3bea0f4e22b9ac68d2ae9f84808; round-10 out_data=3925841d02dc09fbdc118597196a0b32 with out_last=1, out_round=10.
- Back-pressure: hold out_ready=0 after round 3 → in_ready=0, out_data/out_round frozen for 5 cycles; release → round 4 accepted the next cycle with no loss or duplication.
- Full throughput: in_valid=1 and out_ready=1 for 11 consecutive cycles → 11 outputs on consecutive cycles, rounds 0..10.
- Protocol errors: non-start beat in IDLE → no out_valid, seq_err=1. in_start during round 5 → out_round=0 on the next output, seq_err=1.
- Async reset at round 6 with out_valid=1 → out_valid=0 immediately; subsequent in_start block completes normally.
- With AES_RK_STAGE_BLKCNT_EN: three complete blocks → blk_count=3. Preload 0xFFFF then complete one block → blk_count=0.
